hazard_scoreboard: RTL

Producer-side companion to the operand forwarding logic. It sits at the operand-fetch (OF) stage and tracks destination registers whose results cannot yet be forwarded: a load in EX, or an instruction in the multi-cycle EXT unit. When the OF instruction sources such a register, or needs the busy EXT unit, the block stalls OF and bubbles EX, so forwarding only ever sees values that already exist.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_scoreboard_ext_busy_tracker.sv | 78 +++++++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants, EXT FSM state type and the register-match helper for the
// hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned LAT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ext_state_t;

  // True when a used, nonzero source register equals a valid tracked destination
  function automatic logic reg_match(
    input logic [REG_W-1:0] rs,
    input logic             used,
    input logic [REG_W-1:0] rd,
    input logic             valid
  );
    return used && valid && (rs != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_ext_busy_tracker.sv
// EXT unit occupancy tracker: IDLE/BUSY FSM, remaining-cycle counter, the
// destination register of the in-flight EXT op and a one-cycle "just issued"
// flag so a branch flush can kill an EXT op issued on the wrong path.
module ext_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = hazard_pkg::REG_W,
  parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_wr,
  input  logic [REG_W-1:0] start_rd,
  input  logic [LAT_W-1:0] start_lat,
  input  logic             flush,
  output logic             ext_busy,
  output logic [REG_W-1:0] ext_rd
);

  ext_state_t       state;
  ext_state_t       next_state;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] next_cnt;
  logic [REG_W-1:0] next_rd;
  logic             ext_new;
  logic             next_new;

  // State, counter, destination and young-op flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ext_rd  <= '0;
      ext_new <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      ext_rd  <= next_rd;
      ext_new <= next_new;
    end
  end

  // Next-state logic: load on issue, count down while busy, early exit on
  // a flush of the op issued last cycle
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_rd    = ext_rd;
    next_new   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = BUSY;
          next_cnt   = (start_lat == '0) ? LAT_W'(1) : start_lat;
          next_rd    = start_wr ? start_rd : '0;
          next_new   = 1'b1;
        end
      end
      BUSY: begin
        if ((flush && ext_new) || (cnt == LAT_W'(1))) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - LAT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Occupancy is a direct decode of the state register
  assign ext_busy = (state == BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand-fetch hazard scoreboard: stalls OF when a source register is still
// being produced by a load in EX or by the multi-cycle EXT unit, or when the
// OF instruction needs the busy EXT unit.
// Optional feature macro: HAZARD_STATS_EN adds the saturating stall_count port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = hazard_pkg::REG_W,
  parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] of_rs1,
  input  logic [REG_W-1:0] of_rs2,
  input  logic             of_rs1_used,
  input  logic             of_rs2_used,
  input  logic             issue_valid,
  input  logic             issue_wr,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_is_load,
  input  logic             issue_is_ext,
  input  logic [LAT_W-1:0] issue_ext_lat,
  input  logic             flush,
  output logic             stall,
  output logic             ext_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  localparam int unsigned PKG_REG_W = hazard_pkg::REG_W;

  logic             issue_ok;
  logic             ld_valid;
  logic [REG_W-1:0] ld_rd;
  logic [REG_W-1:0] ext_rd;
  logic             hit1;
  logic             hit2;
  logic             struct_hit;

  // A flushed cycle's issue is on the wrong path and never takes effect
  assign issue_ok = issue_valid && !flush;

  // Load tracker: the loaded register is unforwardable for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid <= 1'b0;
      ld_rd    <= '0;
    end else if (issue_ok && issue_is_load && issue_wr && (issue_rd != '0)) begin
      ld_valid <= 1'b1;
      ld_rd    <= issue_rd;
    end else begin
      ld_valid <= 1'b0;
    end
  end

  ext_busy_tracker #(
    .REG_W(REG_W),
    .LAT_W(LAT_W)
  ) u_ext (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (issue_ok && issue_is_ext),
    .start_wr (issue_wr),
    .start_rd (issue_rd),
    .start_lat(issue_ext_lat),
    .flush    (flush),
    .ext_busy (ext_busy),
    .ext_rd   (ext_rd)
  );

  // Stall combine: data hazards on either source plus the EXT structural hazard
  always_comb begin
    hit1 = reg_match(PKG_REG_W'(of_rs1), of_rs1_used, PKG_REG_W'(ld_rd), ld_valid)
         | reg_match(PKG_REG_W'(of_rs1), of_rs1_used, PKG_REG_W'(ext_rd), ext_busy);
    hit2 = reg_match(PKG_REG_W'(of_rs2), of_rs2_used, PKG_REG_W'(ld_rd), ld_valid)
         | reg_match(PKG_REG_W'(of_rs2), of_rs2_used, PKG_REG_W'(ext_rd), ext_busy);
    struct_hit = ext_busy && issue_is_ext;
    stall = hit1 | hit2 | struct_hit;
  end

`ifdef HAZARD_STATS_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
